// File: rtl/mips_fetch_pkg.sv
// -----------------------------------------------------------------------------
// mips_fetch_pkg
//   Shared definitions for the fetch-path NPC sequencer:
//     - RESET_PC / EXC_VEC : architectural fetch addresses
//     - seq_state_e        : sequencer FSM states (SEQ, SLOT)
//     - redir_kind_e       : which redirect, if any, wins this cycle
//     - branch_offset()    : word offset -> signed byte offset
// -----------------------------------------------------------------------------
package mips_fetch_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC  = 32'h0000_4180;

  typedef enum logic {
    SEQ  = 1'b0,  // no pending redirect
    SLOT = 1'b1   // target captured; current PC is the delay slot
  } seq_state_e;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    BR   = 2'd1,
    J    = 2'd2,
    JR   = 2'd3
  } redir_kind_e;

  // Sign-extend a 16-bit word offset and scale it to bytes.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage : mips_fetch_pkg

// File: rtl/npc_target_calc.sv
// -----------------------------------------------------------------------------
// npc_target_calc
//   Purely combinational redirect-target generator. All arithmetic is based on
//   P4 = PC + 4 and wraps modulo 2^32.
//
//   Ports:
//     PC         in  32  current fetch PC
//     br_imm     in  16  signed branch offset in words
//     jmp_idx    in  26  j/jal instr_index
//     jr_addr    in  32  jr/jalr register target
//     kind       in   2  selected redirect (redir_kind_e)
//     target     out 32  redirect target (P4 when kind == NONE)
//     misaligned out  1  register jump to a non-word-aligned address
// -----------------------------------------------------------------------------
module npc_target_calc
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] EXC_VEC_P = EXC_VEC
) (
  input  logic [31:0] PC,
  input  logic [15:0] br_imm,
  input  logic [25:0] jmp_idx,
  input  logic [31:0] jr_addr,
  input  redir_kind_e kind,
  output logic [31:0] target,
  output logic        misaligned
);

  logic [31:0] p4;

  assign p4 = PC + 32'd4;

  // A misaligned register target is diverted to the exception vector so the
  // fetch stream never leaves word alignment.
  assign misaligned = (kind == JR) && (jr_addr[1:0] != 2'b00);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case leaves it unassigned and infers a latch.
    target = p4;
    unique case (kind)
      BR:      target = p4 + branch_offset(br_imm);
      J:       target = {p4[31:28], jmp_idx, 2'b00};
      JR:      target = misaligned ? EXC_VEC_P : jr_addr;
      default: target = p4;
    endcase
  end

endmodule : npc_target_calc

// File: rtl/npc_sequencer.sv
// -----------------------------------------------------------------------------
// npc_sequencer
//   Generates NPC for the PC register and closes the fetch loop with MIPS
//   delayed-branch semantics: a taken redirect is captured, the delay-slot
//   instruction issues at PC+4, then NPC switches to the captured target.
//   With DELAY_SLOT = 0 the redirect is applied in the same cycle instead.
//
//   Ports:
//     clk       in   1  system clock, rising edge
//     reset     in   1  asynchronous active-low reset
//     PC        in  32  current PC from the PC register
//     stall     in   1  hold fetch: NPC = PC, no state change
//     br_taken  in   1  conditional branch resolved taken
//     br_imm    in  16  branch offset in words, signed
//     jmp       in   1  j/jal this cycle
//     jmp_idx   in  26  jump instr_index
//     jr        in   1  jr/jalr this cycle
//     jr_addr   in  32  register target
//     NPC       out 32  next PC
//     in_slot   out  1  current instruction is a delay slot
//     addr_err  out  1  sticky misaligned register-jump flag
//     slot_err  out  1  sticky redirect-inside-delay-slot flag
// -----------------------------------------------------------------------------
module npc_sequencer
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] EXC_VEC_P  = EXC_VEC,
  parameter bit          DELAY_SLOT = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [15:0] br_imm,
  input  logic        jmp,
  input  logic [25:0] jmp_idx,
  input  logic        jr,
  input  logic [31:0] jr_addr,
  output logic [31:0] NPC,
  output logic        in_slot,
  output logic        addr_err,
  output logic        slot_err
);

  seq_state_e  state_q, state_d;
  logic [31:0] tgt_q, tgt_d;
  logic        addr_err_q, addr_err_d;
  logic        slot_err_q, slot_err_d;

  redir_kind_e kind;
  logic [31:0] target;
  logic        misaligned;
  logic [31:0] p4;

  assign p4 = PC + 32'd4;

  // Redirect priority: jr > jmp > br_taken.
  always_comb begin
    kind = NONE;
    if (jr)            kind = JR;
    else if (jmp)      kind = J;
    else if (br_taken) kind = BR;
  end

  npc_target_calc #(
    .EXC_VEC_P (EXC_VEC_P)
  ) u_target_calc (
    .PC         (PC),
    .br_imm     (br_imm),
    .jmp_idx    (jmp_idx),
    .jr_addr    (jr_addr),
    .kind       (kind),
    .target     (target),
    .misaligned (misaligned)
  );

  // Next-state and output logic.
  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    addr_err_d = addr_err_q;
    slot_err_d = slot_err_q;
    NPC        = p4;

    if (stall) begin
      // Refetch the same PC; every register holds, including SLOT.
      NPC = PC;
    end else begin
      unique case (state_q)
        SEQ: begin
          NPC = p4;
          if (kind != NONE) begin
            if (misaligned) addr_err_d = 1'b1;
            if (DELAY_SLOT) begin
              tgt_d   = target;
              state_d = SLOT;
            end else begin
              NPC = target;
            end
          end
        end
        SLOT: begin
          // The delay slot cannot itself redirect: the captured target wins
          // and the attempt is recorded.
          NPC     = tgt_q;
          state_d = SEQ;
          if (kind != NONE) slot_err_d = 1'b1;
        end
        default: begin
          state_d = SEQ;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= SEQ;
      tgt_q      <= '0;
      addr_err_q <= 1'b0;
      slot_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      addr_err_q <= addr_err_d;
      slot_err_q <= slot_err_d;
    end
  end

  assign in_slot  = (state_q == SLOT);
  assign addr_err = addr_err_q;
  assign slot_err = slot_err_q;

endmodule : npc_sequencer

// File: tb/tb_npc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_npc_sequencer
//   Directed bench for npc_sequencer (DELAY_SLOT = 1). Inputs change 1 ns after
//   the rising edge; outputs are compared at the following falling edge.
// -----------------------------------------------------------------------------
module tb_npc_sequencer;
  import mips_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PC;
  logic        stall;
  logic        br_taken;
  logic [15:0] br_imm;
  logic        jmp;
  logic [25:0] jmp_idx;
  logic        jr;
  logic [31:0] jr_addr;
  logic [31:0] NPC;
  logic        in_slot;
  logic        addr_err;
  logic        slot_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  npc_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .PC       (PC),
    .stall    (stall),
    .br_taken (br_taken),
    .br_imm   (br_imm),
    .jmp      (jmp),
    .jmp_idx  (jmp_idx),
    .jr       (jr),
    .jr_addr  (jr_addr),
    .NPC      (NPC),
    .in_slot  (in_slot),
    .addr_err (addr_err),
    .slot_err (slot_err)
  );

  typedef struct {
    logic [31:0] pc;
    logic        stall;
    logic        br;
    logic [15:0] imm;
    logic        jmp;
    logic [25:0] idx;
    logic        jr;
    logic [31:0] jra;
    logic [31:0] npc;
    logic        slot;
    logic        aerr;
    logic        serr;
  } vec_t;

  localparam int NVEC = 21;
  vec_t vecs[NVEC];

  function automatic vec_t mk(input logic [31:0] pc, input logic st,
                              input logic br, input logic [15:0] imm,
                              input logic jp, input logic [25:0] idx,
                              input logic r, input logic [31:0] jra,
                              input logic [31:0] npc, input logic slot,
                              input logic aerr, input logic serr);
    vec_t v;
    v.pc = pc; v.stall = st; v.br = br; v.imm = imm; v.jmp = jp; v.idx = idx;
    v.jr = r; v.jra = jra; v.npc = npc; v.slot = slot; v.aerr = aerr;
    v.serr = serr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] pc, input logic st, input logic br,
                       input logic [15:0] imm, input logic jp,
                       input logic [25:0] idx, input logic r,
                       input logic [31:0] jra);
    PC = pc; stall = st; br_taken = br; br_imm = imm;
    jmp = jp; jmp_idx = idx; jr = r; jr_addr = jra;
  endtask

  task automatic idle(input logic [31:0] pc);
    drive(pc, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
  endtask

  // One cycle: drive after the rising edge, compare at the falling edge.
  task automatic step_check(input string name, input logic [31:0] npc,
                            input logic slot, input logic aerr,
                            input logic serr);
    @(negedge clk);
    check({name, ".npc"},  NPC, npc);
    check({name, ".slot"}, {31'b0, in_slot}, {31'b0, slot});
    check({name, ".aerr"}, {31'b0, addr_err}, {31'b0, aerr});
    check({name, ".serr"}, {31'b0, slot_err}, {31'b0, serr});
  endtask

  initial begin
    // --- vector table (PC driven as the PC register would follow NPC) ---
    //            pc            st  br  imm       jp  idx          jr  jra            npc           sl  ae  se
    vecs[0]  = mk(RESET_PC,     0, 0, 16'h0000, 0, 26'h0,       0, 32'h0,        32'h0000_3004, 0, 0, 0);
    vecs[1]  = mk(32'h0000_3000, 0, 1, 16'h0004, 0, 26'h0,       0, 32'h0,        32'h0000_3004, 0, 0, 0);
    vecs[2]  = mk(32'h0000_3004, 0, 0, 16'h0000, 0, 26'h0,       0, 32'h0,        32'h0000_3014, 1, 0, 0);
    vecs[3]  = mk(32'h0000_3014, 0, 0, 16'h0000, 0, 26'h0,       0, 32'h0,        32'h0000_3018, 0, 0, 0);
    vecs[4]  = mk(32'h0000_3000, 0, 1, 16'hFFFF, 0, 26'h0,       0, 32'h0,        32'h0000_3004, 0, 0, 0);
    vecs[5]  = mk(32'h0000_3004, 0, 0, 16'h0000, 0, 26'h0,       0, 32'h0,        32'h0000_3000, 1, 0, 0);
    vecs[6]  = mk(32'h0000_3008, 0, 0, 16'h0000, 1, 26'h0000C10, 0, 32'h0,        32'h0000_300C, 0, 0, 0);
    vecs[7]  = mk(32'h0000_300C, 0, 0, 16'h0000, 0, 26'h0,       0, 32'h0,        32'h0000_3040, 1, 0, 0);
    // all three redirects at once: jr wins
    vecs[8]  = mk(32'h0000_3040, 0, 1, 16'h0010, 1, 26'h0000100, 1, 32'h0000_5000, 32'h0000_3044, 0, 0, 0);
    vecs[9]  = mk(32'h0000_3044, 0, 0, 16'h0000, 0, 26'h0,       0, 32'h0,        32'h0000_5000, 1, 0, 0);
    // jmp and branch together: jmp wins
    vecs[10] = mk(32'h0000_5000, 0, 1, 16'h0010, 1, 26'h0000040, 0, 32'h0,        32'h0000_5004, 0, 0, 0);
    vecs[11] = mk(32'h0000_5004, 0, 0, 16'h0000, 0, 26'h0,       0, 32'h0,        32'h0000_0100, 1, 0, 0);
    // stall in SEQ swallows a redirect
    vecs[12] = mk(32'h0000_0100, 1, 1, 16'h0040, 0, 26'h0,       0, 32'h0,        32'h0000_0100, 0, 0, 0);
    vecs[13] = mk(32'h0000_0100, 0, 0, 16'h0000, 0, 26'h0,       0, 32'h0,        32'h0000_0104, 0, 0, 0);
    // 32-bit wrap of P4 and of the branch target
    vecs[14] = mk(32'hFFFF_FFFC, 0, 1, 16'h0001, 0, 26'h0,       0, 32'h0,        32'h0000_0000, 0, 0, 0);
    vecs[15] = mk(32'h0000_0000, 0, 0, 16'h0000, 0, 26'h0,       0, 32'h0,        32'h0000_0004, 1, 0, 0);
    // jump keeps P4[31:28]
    vecs[16] = mk(32'hA000_0000, 0, 0, 16'h0000, 1, 26'h3FFFFFF, 0, 32'h0,        32'hA000_0004, 0, 0, 0);
    vecs[17] = mk(32'hA000_0004, 0, 0, 16'h0000, 0, 26'h0,       0, 32'h0,        32'hAFFF_FFFC, 1, 0, 0);
    // misaligned register jump -> exception vector, sticky addr_err
    vecs[18] = mk(32'h0000_3000, 0, 0, 16'h0000, 0, 26'h0,       1, 32'h0000_3002, 32'h0000_3004, 0, 0, 0);
    vecs[19] = mk(32'h0000_3004, 0, 0, 16'h0000, 0, 26'h0,       0, 32'h0,        32'h0000_4180, 1, 1, 0);
    vecs[20] = mk(32'h0000_4180, 0, 0, 16'h0000, 0, 26'h0,       0, 32'h0,        32'h0000_4184, 0, 1, 0);

    // --- reset ---
    reset = 1'b0;
    idle(RESET_PC);
    @(negedge clk);
    check("rst.npc",  NPC, 32'h0000_3004);
    check("rst.slot", {31'b0, in_slot},  32'h0);
    check("rst.aerr", {31'b0, addr_err}, 32'h0);
    check("rst.serr", {31'b0, slot_err}, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // --- table ---
    for (int i = 0; i < NVEC; i++) begin
      @(posedge clk); #1;
      drive(vecs[i].pc, vecs[i].stall, vecs[i].br, vecs[i].imm,
            vecs[i].jmp, vecs[i].idx, vecs[i].jr, vecs[i].jra);
      step_check($sformatf("vec%0d", i), vecs[i].npc, vecs[i].slot,
                 vecs[i].aerr, vecs[i].serr);
    end

    // --- stall held in SLOT for 3 cycles ---
    @(posedge clk); #1;
    drive(32'h0000_3000, 1'b0, 1'b1, 16'h0004, 1'b0, 26'h0, 1'b0, 32'h0);
    step_check("stl.enter", 32'h0000_3004, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      drive(32'h0000_3004, 1'b1, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
      step_check($sformatf("stl.hold%0d", i), 32'h0000_3004, 1'b1, 1'b1, 1'b0);
    end
    @(posedge clk); #1;
    idle(32'h0000_3004);
    step_check("stl.release", 32'h0000_3014, 1'b1, 1'b1, 1'b0);

    // --- redirect inside the delay slot ---
    @(posedge clk); #1;
    drive(32'h0000_3000, 1'b0, 1'b1, 16'h0004, 1'b0, 26'h0, 1'b0, 32'h0);
    step_check("sle.enter", 32'h0000_3004, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    drive(32'h0000_3004, 1'b0, 1'b0, 16'h0, 1'b1, 26'h0000C10, 1'b0, 32'h0);
    step_check("sle.jmp", 32'h0000_3014, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    idle(32'h0000_3014);
    step_check("sle.after", 32'h0000_3018, 1'b0, 1'b1, 1'b1);

    // --- asynchronous reset mid-SLOT ---
    @(posedge clk); #1;
    drive(32'h0000_3000, 1'b0, 1'b1, 16'h0004, 1'b0, 26'h0, 1'b0, 32'h0);
    @(posedge clk); #1;
    idle(32'h0000_3004);
    #1;
    check("ars.pre_slot", {31'b0, in_slot}, 32'h1);
    #1;
    reset = 1'b0;
    #1;
    check("ars.slot", {31'b0, in_slot},  32'h0);
    check("ars.aerr", {31'b0, addr_err}, 32'h0);
    check("ars.serr", {31'b0, slot_err}, 32'h0);
    check("ars.npc",  NPC, 32'h0000_3008);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    idle(RESET_PC);
    step_check("ars.resume", 32'h0000_3004, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_npc_sequencer
